// File: rtl/foreign_dec_seq_if.sv
// Bus bundle between foreign_dec_seq and its neighbours.
//   fb_*   : fetch-byte push into the sequencer queue
//   cfg_*  : subreg_need table chunk writes
//   dec_*  : window issue / table write strobes toward foreign_imul
//   len_*  : instruction-length feedback for the issued window
// master = sequencer side, slave = fetch/config/decoder side.
interface foreign_dec_seq_if;
    logic         fb_valid;
    logic         fb_ready;
    logic [127:0] fb_bytes;
    logic [4:0]   fb_cnt;
    logic         fb_last;

    logic         cfg_valid;
    logic         cfg_ready;
    logic [6:0]   cfg_addr;
    logic [63:0]  cfg_data;

    logic         dec_dataEn;
    logic         dec_subreg_en;
    logic [64:0]  dec_A;
    logic [64:0]  dec_B;

    logic         len_valid;
    logic [3:0]   len;

    modport master (
        input  fb_valid, fb_bytes, fb_cnt, fb_last,
        input  cfg_valid, cfg_addr, cfg_data,
        input  len_valid, len,
        output fb_ready, cfg_ready,
        output dec_dataEn, dec_subreg_en, dec_A, dec_B
    );

    modport slave (
        output fb_valid, fb_bytes, fb_cnt, fb_last,
        output cfg_valid, cfg_addr, cfg_data,
        output len_valid, len,
        input  fb_ready, cfg_ready,
        input  dec_dataEn, dec_subreg_en, dec_A, dec_B
    );
endinterface

// File: rtl/foreign_dec_seq.sv
// foreign_dec_seq: sequencer in front of the foreign_imul x86 pre-decoder.
// Buffers fetched bytes in a circular byte queue, issues 16-byte windows as
// dec_A/dec_B, waits for the length feedback before advancing, and slots
// subreg_need table writes in only while no window is in flight.
// Ports:
//   clk    : clock
//   rst    : synchronous reset, active-low
//   mode64 : copied to dec_A[64] when a window issues
//   flush  : drop queue contents and any in-flight window
//   busy   : window in flight or queue not empty
//   err    : sticky error (bad fb_cnt, bad len, length timeout)
//   bus    : fb_* push, cfg_* table write, dec_* strobes, len_* feedback
module foreign_dec_seq #(
    parameter int unsigned QBYTES  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode64,
    input  logic               flush,
    output logic               busy,
    output logic               err,
    foreign_dec_seq_if.master  bus
);
    localparam int unsigned PW     = $clog2(QBYTES);
    localparam int unsigned OW     = PW + 1;
    localparam int unsigned CW     = $clog2(TIMEOUT + 1);
    localparam int unsigned WBYTES = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [7:0]    q [QBYTES];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] occ;
    logic [CW-1:0] wait_cnt;
    logic          live;

    logic          fb_acc;
    logic          cnt_bad;
    logic          fb_wr;
    logic [OW-1:0] enq;
    logic [PW-1:0] wr_ptr_n;
    logic          cfg_acc;
    logic          len_hit;
    logic          len_ok;
    logic [OW-1:0] deq;
    logic          tmo;
    logic          abort;
    logic          issue_ok;
    logic [63:0]   win_lo;
    logic [63:0]   win_hi;

    // Handshakes; live keeps both low until the first clock out of reset.
    assign bus.fb_ready  = live & (occ <= OW'(QBYTES - WBYTES)) & ~flush;
    assign bus.cfg_ready = live & (state == S_IDLE) & ~flush;

    assign busy = (state != S_IDLE) | (occ != '0);

    // Fetch push: a bad count is accepted (and flagged) but writes nothing.
    assign fb_acc   = bus.fb_valid & bus.fb_ready;
    assign cnt_bad  = (bus.fb_cnt == 5'd0) | (bus.fb_cnt > 5'(WBYTES));
    assign fb_wr    = rst & fb_acc & ~cnt_bad;
    assign enq      = fb_wr ? OW'(bus.fb_cnt) : '0;
    assign wr_ptr_n = wr_ptr + PW'(enq);

    assign cfg_acc  = bus.cfg_valid & bus.cfg_ready;

    // Length feedback only counts while waiting; flush discards it.
    assign len_hit  = (state == S_WAIT) & bus.len_valid & ~flush;
    assign len_ok   = (bus.len != 4'd0) & (OW'(bus.len) <= occ);
    assign deq      = (len_hit & len_ok) ? OW'(bus.len) : '0;
    assign tmo      = (state == S_WAIT) & ~bus.len_valid & ~flush &
                      (wait_cnt == CW'(TIMEOUT - 1));
    assign abort    = (len_hit & ~len_ok) | tmo;

    // A full instruction may be 15 bytes; below that only at end of stream.
    assign issue_ok = (occ >= OW'(WBYTES - 1)) | (bus.fb_last & (occ != '0));

    // Window view of the queue head; bytes past occupancy read as NOP.
    always_comb begin
        win_lo = '0;
        win_hi = '0;
        for (int i = 0; i < 8; i++) begin
            win_lo[8*i +: 8] = (OW'(i) < occ) ? q[rd_ptr + PW'(i)] : 8'h90;
            win_hi[8*i +: 8] = (OW'(i + 8) < occ) ? q[rd_ptr + PW'(i + 8)] : 8'h90;
        end
    end

    // Byte storage; contents past occupancy are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (fb_wr) begin
            for (int i = 0; i < WBYTES; i++) begin
                if (5'(i) < bus.fb_cnt) begin
                    q[wr_ptr + PW'(i)] <= bus.fb_bytes[8*i +: 8];
                end
            end
        end
    end

    // Sequencer FSM, queue pointers and registered decoder outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= S_IDLE;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            occ               <= '0;
            wait_cnt          <= '0;
            live              <= 1'b0;
            err               <= 1'b0;
            bus.dec_dataEn    <= 1'b0;
            bus.dec_subreg_en <= 1'b0;
            bus.dec_A         <= '0;
            bus.dec_B         <= '0;
        end else begin
            live              <= 1'b1;
            bus.dec_dataEn    <= 1'b0;
            bus.dec_subreg_en <= 1'b0;
            bus.dec_A         <= '0;
            bus.dec_B         <= '0;
            wr_ptr            <= wr_ptr_n;

            if (fb_acc && cnt_bad) begin
                err <= 1'b1;
            end

            if (flush) begin
                // fb_ready is low under flush, so wr_ptr is not moving.
                state  <= S_IDLE;
                occ    <= '0;
                rd_ptr <= wr_ptr;
            end else if (abort) begin
                // Drop everything, including a push landing this cycle.
                err    <= 1'b1;
                state  <= S_IDLE;
                occ    <= '0;
                rd_ptr <= wr_ptr_n;
            end else begin
                occ    <= occ + enq - deq;
                rd_ptr <= rd_ptr + PW'(deq);
                unique case (state)
                    S_IDLE: begin
                        if (cfg_acc) begin
                            state             <= S_CFG;
                            bus.dec_subreg_en <= 1'b1;
                            bus.dec_A         <= {1'b0, bus.cfg_data};
                            bus.dec_B         <= {58'b0, bus.cfg_addr};
                        end else if (issue_ok) begin
                            state          <= S_ISSUE;
                            bus.dec_dataEn <= 1'b1;
                            bus.dec_A      <= {mode64, win_lo};
                            bus.dec_B      <= {1'b0, win_hi};
                        end
                    end
                    S_CFG: begin
                        state <= S_IDLE;
                    end
                    S_ISSUE: begin
                        state    <= S_WAIT;
                        wait_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (bus.len_valid) begin
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
